calc_arbiter: RTL and testbench
===============================

// Module: calc_arbiter
// PURPOSE
//   Shares one combinational basic calculator (8b A/B, 2b opcode, 16b result,
//   error_flag) between two requesters. Round-robin arbitration, valid/ready
//   request and response channels, registered operands, LAT-cycle compute wait.
//   Sits between requester logic and the calculator instance at the top level.
// PARAMETERS
//   DATA_W  8  operand width; result width is 2*DATA_W
//   LAT     1  cycles from operand launch to result sample; must be >= 1
// PORTS
//   clk                      in   1         system clock, rising edge
//   rst_n                    in   1         async reset, active low
//   req0_valid / req1_valid  in   1         request present on requester N
//   req0_ready / req1_ready  out  1         request accepted this cycle
//   req0_a / req1_a          in   DATA_W    operand A
//   req0_b / req1_b          in   DATA_W    operand B
//   req0_op / req1_op        in   2         00 add, 01 sub, 10 mul, 11 div
//   rsp_valid                out  1         response available
//   rsp_ready                in   1         consumer takes response
//   rsp_id                   out  1         requester that issued the op
//   rsp_result               out  2*DATA_W  calculator result
//   rsp_error                out  1         calculator error_flag (div by 0)
//   calc_a / calc_b          out  DATA_W    to calculator A / B
//   calc_op                  out  2         to calculator opcode
//   calc_result              in   2*DATA_W  from calculator result
//   calc_error               in   1         from calculator error_flag
// BEHAVIOUR
//   - Reset (async, rst_n=0): FSM=IDLE, last_grant=1 (req0 wins first tie),
//     all outputs 0 (rsp_*, calc_*, reqN_ready); in-flight op dropped, no response.
//   - FSM IDLE -> EXEC -> RESP -> IDLE. One op in flight at most.
//   - IDLE: grant = only valid requester; both valid -> requester != last_grant.
//     reqN_ready = (FSM==IDLE) && grant==N (combinational). No valid -> both 0.
//   - Accept on valid&&ready edge: latch a/b/op onto calc_*, latch rsp_id,
//     last_grant<=N, counter<=LAT, FSM->EXEC. last_grant changes only on accept.
//   - EXEC: counter decrements per cycle; at edge where counter==1, sample
//     calc_result/calc_error into rsp_result/rsp_error, rsp_valid<=1, FSM->RESP.
//     Latency: rsp_valid high exactly LAT cycles after the accepting edge.
//   - calc_* hold the accepted operands from accept until next accept.
//   - RESP: rsp_* held stable while rsp_ready=0; on rsp_valid&&rsp_ready,
//     rsp_valid<=0, FSM->IDLE. No accept in same cycle as response handshake.
//     Min issue interval LAT+2 cycles.
//   - rsp_ready ignored when rsp_valid=0. Requester may drop valid before
//     ready without effect; operands sampled only at accept edge.
//   - Result/error passed through unmodified; op encoding unchanged.
// CONFIGURATION
//   CALC_ARB_STATS_EN defined: adds outputs stat_ops0, stat_ops1, stat_err
//     (16b each): count response handshakes per rsp_id, and those with
//     rsp_error=1; saturate at 16'hFFFF; reset to 0.
//   Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//   1. req0 A=10 B=5 op=00, LAT=1, rsp_ready=1 -> rsp_result=15, id=0,
//      error=0, rsp_valid 1 cycle after accept.
//   2. Post-reset both valid: req0 4*3 (10), req1 10-5 (01) -> req0 first
//      (12), then req1 (5); next simultaneous pair -> req0 granted again.
//   3. req1 8/0 op=11 -> rsp_error=1, id=1; then 8/2 -> result 4, error 0.
//   4. rsp_ready low 5 cycles in RESP -> rsp_* stable, req0/1_ready stay 0,
//      pending req1 accepted only after response handshake.
//   5. LAT=3: accept->rsp_valid exactly 3 cycles; rst_n low during EXEC ->
//      outputs 0 at once, no response after release, next op served normally.
//   6. CALC_ARB_STATS_EN: 3 ops on req0, one 8/0 on req1 -> stat_ops0=3,
//      stat_ops1=1, stat_err=1.

Source files
------------

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin sharing of one combinational calculator between two requesters.
// Define CALC_ARB_STATS_EN to add saturating per-requester / error handshake counters.

module calc_arbiter #(
  parameter int DATA_W = 8,
  parameter int LAT    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic [1:0]          req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  input  logic [1:0]          req1_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic                rsp_error,
  output logic [DATA_W-1:0]   calc_a,
  output logic [DATA_W-1:0]   calc_b,
  output logic [1:0]          calc_op,
  input  logic [2*DATA_W-1:0] calc_result,
  input  logic                calc_error
`ifdef CALC_ARB_STATS_EN
  ,
  output logic [15:0]         stat_ops0,
  output logic [15:0]         stat_ops1,
  output logic [15:0]         stat_err
`endif
);

  // state | meaning
  // IDLE  | nothing in flight; arbitrate and accept one request
  // EXEC  | operands driven on calc_*, counting down LAT cycles
  // RESP  | response held on rsp_* until the consumer takes it
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT + 1) : 1;

  state_t              r_state;
  logic                r_last_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [2*DATA_W-1:0] r_rsp_result;
  logic                r_rsp_error;
  logic [DATA_W-1:0]   r_calc_a;
  logic [DATA_W-1:0]   r_calc_b;
  logic [1:0]          r_calc_op;

  logic w_idle;
  logic w_acc0;
  logic w_acc1;
  logic w_rsp_hs;

  // Ready is gated by rst_n so nothing is offered while reset is asserted.
  assign w_idle     = rst_n && (r_state == S_IDLE);
  assign req0_ready = w_idle && req0_valid && (!req1_valid || r_last_grant);
  assign req1_ready = w_idle && req1_valid && (!req0_valid || !r_last_grant);
  assign w_acc0     = req0_valid && req0_ready;
  assign w_acc1     = req1_valid && req1_ready;
  assign w_rsp_hs   = r_rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_error  <= 1'b0;
      r_calc_a     <= '0;
      r_calc_b     <= '0;
      r_calc_op    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc0 || w_acc1) begin
            r_calc_a     <= w_acc1 ? req1_a  : req0_a;
            r_calc_b     <= w_acc1 ? req1_b  : req0_b;
            r_calc_op    <= w_acc1 ? req1_op : req0_op;
            r_rsp_id     <= w_acc1;
            r_last_grant <= w_acc1;
            r_cnt        <= CNT_W'(LAT);
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == CNT_W'(1)) begin
            r_rsp_result <= calc_result;
            r_rsp_error  <= calc_error;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_error  = r_rsp_error;
  assign calc_a     = r_calc_a;
  assign calc_b     = r_calc_b;
  assign calc_op    = r_calc_op;

`ifdef CALC_ARB_STATS_EN
  logic [15:0] r_stat_ops0;
  logic [15:0] r_stat_ops1;
  logic [15:0] r_stat_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_ops0 <= '0;
      r_stat_ops1 <= '0;
      r_stat_err  <= '0;
    end else if (w_rsp_hs) begin
      if (!r_rsp_id && (r_stat_ops0 != 16'hFFFF)) r_stat_ops0 <= r_stat_ops0 + 16'd1;
      if (r_rsp_id && (r_stat_ops1 != 16'hFFFF))  r_stat_ops1 <= r_stat_ops1 + 16'd1;
      if (r_rsp_error && (r_stat_err != 16'hFFFF)) r_stat_err <= r_stat_err + 16'd1;
    end
  end

  assign stat_ops0 = r_stat_ops0;
  assign stat_ops1 = r_stat_ops1;
  assign stat_err  = r_stat_err;
`endif

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: directed vectors, tie/stall/reset sequences and a randomized run
// against a transaction-level model for calc_arbiter (LAT=1 and LAT=3 instances).

module tb_calc_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stand-in for the shared calculator: {error, result}.
  function automatic logic [16:0] calc_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    logic [15:0] r;
    logic        e;
    e = 1'b0;
    r = 16'd0;
    case (op)
      2'd0: r = {8'd0, a} + {8'd0, b};
      2'd1: r = {8'd0, a} - {8'd0, b};
      2'd2: r = {8'd0, a} * {8'd0, b};
      default: begin
        if (b == 8'd0) e = 1'b1;
        else           r = {8'd0, a / b};
      end
    endcase
    return {e, r};
  endfunction

  // ---------------- LAT=1 instance ----------------
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_error;
  logic [15:0] rsp_result, calc_result;
  logic [7:0]  calc_a, calc_b;
  logic [1:0]  calc_op;
  logic        calc_error;
  assign {calc_error, calc_result} = calc_fn(calc_a, calc_b, calc_op);

  // ---------------- LAT=3 instance ----------------
  logic        rst3_n;
  logic        q0v3, q0r3, q1v3, q1r3;
  logic [7:0]  a3, b3, z3;
  logic [1:0]  op3, zop3;
  logic        rsp_valid3, rsp_ready3, rsp_id3, rsp_error3;
  logic [15:0] rsp_result3, calc_result3;
  logic [7:0]  calc_a3, calc_b3;
  logic [1:0]  calc_op3;
  logic        calc_error3;
  assign {calc_error3, calc_result3} = calc_fn(calc_a3, calc_b3, calc_op3);

`ifdef CALC_ARB_STATS_EN
  logic [15:0] stat_ops0, stat_ops1, stat_err;
  logic [15:0] stat3_ops0, stat3_ops1, stat3_err;
`endif

  calc_arbiter #(.DATA_W(8), .LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op),
    .calc_result(calc_result), .calc_error(calc_error)
`ifdef CALC_ARB_STATS_EN
    , .stat_ops0(stat_ops0), .stat_ops1(stat_ops1), .stat_err(stat_err)
`endif
  );

  calc_arbiter #(.DATA_W(8), .LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .req0_valid(q0v3), .req0_ready(q0r3), .req0_a(a3), .req0_b(b3), .req0_op(op3),
    .req1_valid(q1v3), .req1_ready(q1r3), .req1_a(z3), .req1_b(z3), .req1_op(zop3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_result(rsp_result3),
    .rsp_error(rsp_error3), .calc_a(calc_a3), .calc_b(calc_b3), .calc_op(calc_op3),
    .calc_result(calc_result3), .calc_error(calc_error3)
`ifdef CALC_ARB_STATS_EN
    , .stat_ops0(stat3_ops0), .stat_ops1(stat3_ops1), .stat_err(stat3_err)
`endif
  );

  typedef struct {
    logic        id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_main();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_ready(input logic id);
    int n;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      step();
      n++;
    end
    chk("ready_seen", id ? req1_ready : req0_ready, 1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("rsp_seen", rsp_valid, 1);
  endtask

  task automatic hs();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
    end
    #1;
    wait_ready(v.id);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(n);
    chk("vec_latency", n, 1);
    chk("vec_id", rsp_id, v.id);
    chk("vec_result", rsp_result, v.res);
    chk("vec_error", rsp_error, v.err);
    chk("vec_calc_a", calc_a, v.a);
    chk("vec_calc_b", calc_b, v.b);
    chk("vec_calc_op", calc_op, v.op);
    hs();
    chk("vec_rsp_clear", rsp_valid, 0);
  endtask

  task automatic wait_rsp3(output int n);
    n = 0;
    while (!rsp_valid3 && n < 20) begin
      step();
      n++;
    end
    chk("rsp3_seen", rsp_valid3, 1);
  endtask

  task automatic op3_issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    q0v3 = 1'b1; a3 = a; b3 = b; op3 = op;
    #1;
    chk("lat3_ready", q0r3, 1);
    step();
    q0v3 = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int   n;
    logic busy, last, have, g0, g1, ev, eid;
    int   edges, acc_edge;
    logic [7:0]  ea, eb;
    logic [1:0]  eop;
    logic [16:0] eexp;

    tbl[0] = '{1'b0, 8'd10,  8'd5,   2'd0, 16'd15,    1'b0};
    tbl[1] = '{1'b1, 8'd8,   8'd0,   2'd3, 16'd0,     1'b1};
    tbl[2] = '{1'b1, 8'd8,   8'd2,   2'd3, 16'd4,     1'b0};
    tbl[3] = '{1'b0, 8'd4,   8'd3,   2'd2, 16'd12,    1'b0};
    tbl[4] = '{1'b1, 8'd10,  8'd5,   2'd1, 16'd5,     1'b0};
    tbl[5] = '{1'b0, 8'd3,   8'd5,   2'd1, 16'hFFFE,  1'b0};
    tbl[6] = '{1'b0, 8'd255, 8'd255, 2'd2, 16'hFE01,  1'b0};
    tbl[7] = '{1'b1, 8'd200, 8'd100, 2'd0, 16'd300,   1'b0};
    tbl[8] = '{1'b0, 8'd255, 8'd0,   2'd3, 16'd0,     1'b1};
    tbl[9] = '{1'b1, 8'd100, 8'd7,   2'd3, 16'd14,    1'b0};

    rst_n = 1'b0; rst3_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 8'd0; req0_b = 8'd0; req0_op = 2'd0;
    req1_a = 8'd0; req1_b = 8'd0; req1_op = 2'd0;
    q0v3 = 1'b0; q1v3 = 1'b0; a3 = 8'd0; b3 = 8'd0; op3 = 2'd0;
    z3 = 8'd0; zop3 = 2'd0; rsp_ready3 = 1'b0;
    repeat (3) step();

    // Reset state, with a request pending that must not be offered ready.
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_calc_a", calc_a, 0);
    chk("rst_calc_b", calc_b, 0);
    chk("rst_calc_op", calc_op, 0);
    chk("rst_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    rst_n = 1'b1; rst3_n = 1'b1;
    step();
    chk("idle_noreq_r0", req0_ready, 0);
    chk("idle_noreq_r1", req1_ready, 0);

    // First tie after reset goes to req0, then req1 is served.
    req0_valid = 1'b1; req0_a = 8'd4;  req0_b = 8'd3; req0_op = 2'd2;
    req1_valid = 1'b1; req1_a = 8'd10; req1_b = 8'd5; req1_op = 2'd1;
    #1;
    chk("tie1_r0", req0_ready, 1);
    chk("tie1_r1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    chk("busy_r1", req1_ready, 0);
    wait_rsp(n);
    chk("tie1_lat", n, 1);
    chk("tie1_id", rsp_id, 0);
    chk("tie1_res", rsp_result, 12);
    hs();
    chk("tie1_clear", rsp_valid, 0);
    chk("tie1_next_r1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    wait_rsp(n);
    chk("tie1b_id", rsp_id, 1);
    chk("tie1b_res", rsp_result, 5);
    hs();

    // Second tie (last grant was req1) goes to req0; then stall the response.
    req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd1; req0_op = 2'd0;
    req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd1; req1_op = 2'd0;
    #1;
    chk("tie2_r0", req0_ready, 1);
    chk("tie2_r1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    wait_rsp(n);
    req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1; req0_op = 2'd0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_id", rsp_id, 0);
      chk("stall_res", rsp_result, 8);
      chk("stall_r0", req0_ready, 0);
      chk("stall_r1", req1_ready, 0);
      step();
    end
    hs();
    chk("post_stall_r1", req1_ready, 1);
    chk("post_stall_r0", req0_ready, 0);
    step();
    req1_valid = 1'b0;
    wait_rsp(n);
    chk("post_stall_id", rsp_id, 1);
    chk("post_stall_res", rsp_result, 10);
    hs();
    chk("pend0_r0", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    wait_rsp(n);
    chk("pend0_id", rsp_id, 0);
    chk("pend0_res", rsp_result, 2);
    hs();

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // Randomized run against a transaction-level model.
    reset_main();
    busy = 1'b0; last = 1'b1; have = 1'b0;
    edges = 0; acc_edge = 0; eid = 1'b0;
    ea = 8'd0; eb = 8'd0; eop = 2'd0; eexp = 17'd0;
    for (int c = 0; c < 3000; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req0_a     = 8'($urandom);
      req0_b     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      req0_op    = 2'($urandom);
      req1_valid = 1'($urandom_range(0, 1));
      req1_a     = 8'($urandom);
      req1_b     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      req1_op    = 2'($urandom);
      rsp_ready  = ($urandom_range(0, 9) < 6);
      #1;
      g0 = !busy && req0_valid && (!req1_valid || last);
      g1 = !busy && req1_valid && (!req0_valid || !last);
      ev = busy && ((edges - acc_edge) >= 1);
      chk("rnd_r0", req0_ready, g0);
      chk("rnd_r1", req1_ready, g1);
      chk("rnd_rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rnd_id", rsp_id, eid);
        chk("rnd_res", rsp_result, eexp[15:0]);
        chk("rnd_err", rsp_error, eexp[16]);
      end
      if (have) begin
        chk("rnd_calc_a", calc_a, ea);
        chk("rnd_calc_b", calc_b, eb);
        chk("rnd_calc_op", calc_op, eop);
      end
      step();
      edges++;
      if (g0 || g1) begin
        busy = 1'b1; have = 1'b1; acc_edge = edges; last = g1; eid = g1;
        ea   = g1 ? req1_a  : req0_a;
        eb   = g1 ? req1_b  : req0_b;
        eop  = g1 ? req1_op : req0_op;
        eexp = calc_fn(ea, eb, eop);
      end else if (ev && rsp_ready) begin
        busy = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

    // LAT=3: exact latency, then reset in the middle of EXEC.
    op3_issue(8'd5, 8'd6, 2'd0);
    wait_rsp3(n);
    chk("lat3_latency", n, 3);
    chk("lat3_res", rsp_result3, 11);
    chk("lat3_id", rsp_id3, 0);
    rsp_ready3 = 1'b1; step(); rsp_ready3 = 1'b0;
    op3_issue(8'd20, 8'd4, 2'd3);
    step();
    rst3_n = 1'b0;
    #1;
    chk("rst3_valid", rsp_valid3, 0);
    chk("rst3_calc_a", calc_a3, 0);
    chk("rst3_calc_b", calc_b3, 0);
    chk("rst3_calc_op", calc_op3, 0);
    chk("rst3_res", rsp_result3, 0);
    step();
    rst3_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst3_no_rsp", rsp_valid3, 0);
    end
    op3_issue(8'd20, 8'd4, 2'd3);
    wait_rsp3(n);
    chk("post_rst3_latency", n, 3);
    chk("post_rst3_res", rsp_result3, 5);
    chk("post_rst3_err", rsp_error3, 0);
    rsp_ready3 = 1'b1; step(); rsp_ready3 = 1'b0;

`ifdef CALC_ARB_STATS_EN
    reset_main();
    chk("stat_rst_ops0", stat_ops0, 0);
    chk("stat_rst_ops1", stat_ops1, 0);
    chk("stat_rst_err", stat_err, 0);
    run_vec(tbl[0]);
    run_vec(tbl[3]);
    run_vec(tbl[5]);
    run_vec(tbl[1]);
    chk("stat_ops0", stat_ops0, 3);
    chk("stat_ops1", stat_ops1, 1);
    chk("stat_err", stat_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
